// File: rtl/mssd_pkg.sv
// ============================================================================
// Module      : mssd_pkg
// Description : Shared MSSD link definitions (frame field widths, line idle
//               level and the frame state encoding), used by TX and RX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mssd_pkg;

    localparam int   PORT_W     = 2;
    localparam int   LEN_W      = 4;
    localparam int   HDR_BITS   = 7;     // start + port + length
    localparam logic IDLE_LEVEL = 1'b1;

    // Explicitly encoded frame states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_PORT  = 3'd2,
        ST_LEN   = 3'd3,
        ST_DATA  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mssd_tx_if.sv
// ============================================================================
// Module      : mssd_tx_if
// Description : Host-side request bus plus serial line of the MSSD
//               transmitter. The host is the master, the transmitter the slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mssd_tx_if #(
    parameter int DATA_W = 16
) ();
    import mssd_pkg::*;

    logic              start;
    logic [PORT_W-1:0] port;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              busy;
    logic              serOut;
    logic              done;

    modport master (
        output start, port, len, data,
        input  ready, busy, serOut, done
    );

    modport slave (
        input  start, port, len, data,
        output ready, busy, serOut, done
    );

endinterface

`default_nettype wire

// File: rtl/mssd_bit_timer.sv
// ============================================================================
// Module      : mssd_bit_timer
// Description : Bit-period timer. Counts CLKS_PER_BIT cycles while enabled
//               and ticks on the last cycle of each bit; held at 0 when idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mssd_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  wire logic clk,
    input  wire logic rst,     // synchronous, active low
    input  wire logic en,
    output logic      tick
);

    localparam int              c_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_w-1:0]  c_last = c_w'(CLKS_PER_BIT - 1);

    logic [c_w-1:0] r_cnt;

    assign tick = en && (r_cnt == c_last);

    // Count cycles within the current bit, wrapping to 0 on tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!en || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mssd_tx.sv
// ============================================================================
// Module      : mssd_tx
// Description : MSSD serial frame transmitter. Sends start bit, 2-bit port
//               (MSB first), 4-bit length N (MSB first) and N data bits
//               (LSB first), then returns the line to idle high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mssd_tx
    import mssd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 16
) (
    input  wire logic  clk,
    input  wire logic  rst,        // synchronous, active low
    mssd_tx_if.slave   bus
);

    localparam int             c_shift_w  = PORT_W + LEN_W + DATA_W;
    localparam logic [3:0]     c_port_last = 4'(PORT_W - 1);
    localparam logic [3:0]     c_len_last  = 4'(LEN_W - 1);

    state_t                 r_state;
    logic [c_shift_w-1:0]   r_shift;
    logic [3:0]             r_bitcnt;
    logic [LEN_W-1:0]       r_len;
    logic                   r_ser;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_tick;
    logic                   w_accept;
    logic [DATA_W-1:0]      w_data_rev;
    logic [c_shift_w-1:0]   w_shift_next;
    logic                   w_ser_next;

    // Data goes out LSB first, so store it bit-reversed behind the header
    // and let the whole frame shift out of the MSB.
    for (genvar i = 0; i < DATA_W; i++) begin : g_rev
        assign w_data_rev[i] = bus.data[DATA_W-1-i];
    end

    assign w_accept     = bus.start & r_ready;
    assign w_ser_next   = r_shift[c_shift_w-1];
    assign w_shift_next = {r_shift[c_shift_w-2:0], 1'b0};

    assign bus.ready  = r_ready;
    assign bus.busy   = r_busy;
    assign bus.serOut = r_ser;
    assign bus.done   = r_done;

    mssd_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (r_busy),
        .tick (w_tick)
    );

    // Frame sequencer with registered line and handshake outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_len    <= '0;
            r_ser    <= IDLE_LEVEL;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift  <= {bus.port, bus.len, w_data_rev};
                        r_len    <= bus.len;
                        r_bitcnt <= '0;
                        r_ser    <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_ser    <= w_ser_next;
                        r_shift  <= w_shift_next;
                        r_bitcnt <= '0;
                        r_state  <= ST_PORT;
                    end
                end
                ST_PORT: begin
                    if (w_tick) begin
                        r_ser    <= w_ser_next;
                        r_shift  <= w_shift_next;
                        if (r_bitcnt == c_port_last) begin
                            r_bitcnt <= '0;
                            r_state  <= ST_LEN;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                end
                ST_LEN: begin
                    if (w_tick) begin
                        if (r_bitcnt == c_len_last && r_len == '0) begin
                            // Empty payload: frame ends after the length field
                            r_ser    <= IDLE_LEVEL;
                            r_ready  <= 1'b1;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_bitcnt <= '0;
                            r_state  <= ST_IDLE;
                        end else if (r_bitcnt == c_len_last) begin
                            r_ser    <= w_ser_next;
                            r_shift  <= w_shift_next;
                            r_bitcnt <= '0;
                            r_state  <= ST_DATA;
                        end else begin
                            r_ser    <= w_ser_next;
                            r_shift  <= w_shift_next;
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        // r_len >= 1 here, so len-1 never underflows
                        if (r_bitcnt == r_len - 4'd1) begin
                            r_ser    <= IDLE_LEVEL;
                            r_ready  <= 1'b1;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_bitcnt <= '0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_ser    <= w_ser_next;
                            r_shift  <= w_shift_next;
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_ser   <= IDLE_LEVEL;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mssd_tx.sv
// ============================================================================
// Module      : tb_mssd_tx
// Description : Self-checking bench for mssd_tx: table of frames with
//               hand-computed line bit sequences, plus reset, ignored-start,
//               back-to-back and abort sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mssd_tx;

    localparam int CPB  = 4;
    localparam int NVEC = 5;

    typedef struct {
        logic [1:0]  port;
        logic [3:0]  len;
        logic [15:0] data;
        logic [22:0] exp;    // line bits incl. start bit, first bit at [22]
        int          nbits;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    vec_t vecs [NVEC];

    mssd_tx_if #(.DATA_W(16)) bus ();

    mssd_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {serOut, ready, busy, done} must read idle
    task automatic check_idle(input string name);
        check(name, {28'd0, bus.serOut, bus.ready, bus.busy, bus.done}, 32'b1100);
    endtask

    // Send one table frame and check every cycle of every bit, then done.
    // preloaded: request already accepted in the previous done cycle.
    // chain: hold start with the next vector so it is taken at done.
    task automatic run_frame(input int idx, input bit preloaded, input bit chain,
                             input int next_idx, input int pulse_at);
        vec_t v;
        vec_t nv;
        int   cyc;
        bit   bit_ok;
        v  = vecs[idx];
        nv = vecs[next_idx];
        if (!preloaded) begin
            @(negedge clk);
            check($sformatf("v%0d_ready_before", idx), {31'd0, bus.ready}, 32'd1);
            bus.port  = v.port;
            bus.len   = v.len;
            bus.data  = v.data;
            bus.start = 1'b1;
        end
        for (int b = 0; b < v.nbits; b++) begin
            bit_ok = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (bus.serOut !== v.exp[22-b] || bus.busy !== 1'b1 ||
                    bus.ready !== 1'b0 || bus.done !== 1'b0)
                    bit_ok = 1'b0;
                cyc = b * CPB + c;
                if (cyc == 0) begin
                    bus.start = 1'b0;
                    bus.port  = ~v.port;
                    bus.len   = ~v.len;
                    bus.data  = ~v.data;
                end
                if (pulse_at > 0 && cyc == pulse_at)     bus.start = 1'b1;
                if (pulse_at > 0 && cyc == pulse_at + 1) bus.start = 1'b0;
                if (chain && cyc == v.nbits * CPB - 1) begin
                    bus.port  = nv.port;
                    bus.len   = nv.len;
                    bus.data  = nv.data;
                    bus.start = 1'b1;
                end
            end
            check($sformatf("v%0d_bit%0d", idx, b), {31'd0, bit_ok}, 32'd1);
        end
        @(negedge clk);
        check($sformatf("v%0d_done_cycle", idx),
              {28'd0, bus.serOut, bus.ready, bus.busy, bus.done}, 32'b1101);
        if (!chain) begin
            @(negedge clk);
            check_idle($sformatf("v%0d_after_done", idx));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0] = '{port: 2'b01, len: 4'd7,  data: 16'h0016,
                    exp: {14'b00101110110100, 9'b0},  nbits: 14};
        vecs[1] = '{port: 2'b11, len: 4'd0,  data: 16'hFFFF,
                    exp: {7'b0110000, 16'b0},         nbits: 7};
        vecs[2] = '{port: 2'b10, len: 4'd15, data: 16'hA5C3,
                    exp: {22'b0101111110000111010010, 1'b0}, nbits: 22};
        vecs[3] = '{port: 2'b00, len: 4'd1,  data: 16'hFFFE,
                    exp: {8'b00000010, 15'b0},        nbits: 8};
        vecs[4] = '{port: 2'b10, len: 4'd3,  data: 16'h0005,
                    exp: {10'b0100011101, 13'b0},     nbits: 10};

        // Reset held with start asserted: line stays idle
        rst       = 1'b0;
        bus.start = 1'b1;
        bus.port  = 2'b01;
        bus.len   = 4'd7;
        bus.data  = 16'h0016;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("reset_%0d", i));
        end
        rst       = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check_idle("post_reset_idle");

        // Table of frames
        for (int i = 0; i < NVEC; i++)
            run_frame(i, 1'b0, 1'b0, 0, 0);

        // Start pulse mid-frame is ignored
        run_frame(0, 1'b0, 1'b0, 0, 10);

        // Back-to-back: start held at done, one idle cycle between frames
        run_frame(3, 1'b0, 1'b1, 4, 0);
        run_frame(4, 1'b1, 1'b0, 0, 0);

        // Abort during the data field
        @(negedge clk);
        bus.port  = vecs[0].port;
        bus.len   = vecs[0].len;
        bus.data  = vecs[0].data;
        bus.start = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            if (c == 0) bus.start = 1'b0;
        end
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort_idle");
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort_no_done");
        run_frame(2, 1'b0, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
